patient_button_responder: RTL and testbench
===========================================

// Module: patient_button_responder
// PURPOSE
//  Device-side end of the patient button / pedal two-wire scan link. Sits in the remote
//  button/pedal unit on one open-drain line. Detects the host start pulse, then answers
//  with a 5-bit pulse-width-coded frame carrying the 4 key states.
//  Instantiate once per line: button line, and pedal line with shorter start and SLOT_START.
// PARAMETERS
//  MIN_START   2    min accepted start-pulse low width, clk cycles
//  MAX_START   12   max accepted start-pulse low width, clk cycles
//  SLOT_START  16   cycles from start falling edge to slot 0 start (pedal line: 13)
//  SLOT_LEN    11   slot period, cycles
//  ONE_LOW     2    low time in a slot for bit '1' (ends before host sample point)
//  ZERO_LOW    8    low time in a slot for bit '0' (covers host sample point)
//  GUARD       20   dead time after frame; line ignored
//  CNT_W       8    width of the frame timer (must hold SLOT_START+5*SLOT_LEN)
// PORTS
//  clk        in   1  system clock, 1 MHz
//  rst        in   1  asynchronous reset, active-high
//  lineIn     in   1  sensed level of the wired line (async, 2-FF synchronised inside)
//  lineOut    out  1  line drive: 0 = pull low, 1 = release
//  keyState   in   4  key pressed flags, active-high
//  busy       out  1  high from accepted start until end of GUARD
//  frameSent  out  1  one-cycle pulse after the last slot ends
//  startErr   out  1  one-cycle pulse when the start pulse exceeds MAX_START
// BEHAVIOUR
//  - Reset (async): lineOut=1, busy=0, frameSent=0, startErr=0, state IDLE, timer=0.
//    Reset mid-frame releases the line immediately; no partial frame resumes.
//  - All timing is measured on synchronised lineIn (edge t0 = first cycle sync==0).
//  - IDLE: on sync falling edge -> START; timer cleared, counts every cycle.
//  - START: while low, timer counts. Timer reaching MAX_START+1 -> pulse startErr, go to ABORT.
//    Rising edge with width<MIN_START -> IDLE, silent (glitch).
//    Valid rising edge -> snapshot frame, busy=1, TX; timer keeps running from t0.
//  - ABORT: wait for sync==1, then IDLE; no frame is sent.
//  - Frame bits, sent b4 first: b4=~keyState[0], b3=reserved, b2=~keyState[1],
//    b1=~keyState[2], b0=~keyState[3] (line-level 1 = released).
//  - TX: slot k (0..4) starts at t0+SLOT_START+k*SLOT_LEN.
//    lineOut=0 for ONE_LOW cycles (bit 1) or ZERO_LOW cycles (bit 0), else 1.
//    Each slot has exactly one falling edge, so the host sees 5 edges per valid frame.
//  - lineIn is ignored in TX and GUARD (own drive, or host activity).
//  - If the start rises after SLOT_START, the frame is still timed from t0; late slots are skipped.
//  - End of slot 4 (t0+SLOT_START+5*SLOT_LEN): frameSent pulse, GUARD for GUARD cycles, then busy=0, IDLE.
//  - keyState changes after the snapshot affect only the next frame.
//  - The timer saturates at all-ones; it never wraps.
// CONFIGURATION
//  PBR_PARITY_EN defined: b3 = b4^b2^b1^b0 (even parity over the 5 bits).
//  PBR_PARITY_EN undefined: b3 = 1 constant.
// TESTING
//  1 Start low 8 cycles, keyState=0 -> lows of 2 cycles at t0+16,27,38,49,60.
//    Host samples at t0+21+11k read 11111; frameSent at t0+71.
//  2 keyState=4'b0001, no parity -> slot0 low t0+16..t0+23 (8 cycles), slots1-4 low 2 cycles.
//  3 Start low 1 cycle -> no drive, no startErr.
//    Start low 20 cycles -> startErr at t0+13, no frame; next valid start answered.
//  4 Second start pulse during GUARD -> ignored, busy stays 1; start after GUARD accepted.
//  5 keyState toggled at t0+30 -> current frame unchanged, next frame reflects change.
//  6 keyState=4'b0011: with PBR_PARITY_EN b3=0 (slot1 low 8 cycles), without b3=1 (2 cycles).
//    Assert rst at t0+40 -> lineOut=1 immediately, busy=0.

Source files
------------

// File: rtl/patient_button_responder.sv
// Device end of the patient button/pedal scan link: detects the host start pulse and answers with a
// 5-slot pulse-width-coded frame of the key states. Optional macro PBR_PARITY_EN puts even parity in b3.
module patient_button_responder #(
  parameter int unsigned MIN_START  = 2,
  parameter int unsigned MAX_START  = 12,
  parameter int unsigned SLOT_START = 16,
  parameter int unsigned SLOT_LEN   = 11,
  parameter int unsigned ONE_LOW    = 2,
  parameter int unsigned ZERO_LOW   = 8,
  parameter int unsigned GUARD      = 20,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lineIn,
  output logic       lineOut,
  input  logic [3:0] keyState,
  output logic       busy,
  output logic       frameSent,
  output logic       startErr
);

  localparam int unsigned FRAME_END = SLOT_START + 5 * SLOT_LEN;

  typedef enum logic [2:0] {S_IDLE, S_START, S_ABORT, S_TX, S_GUARD} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   timer, timer_n, timer_inc;
  logic [4:0]         frame, frame_n, snap;
  logic               busy_n, frame_sent_n, start_err_n, line_out_n;
  logic               sync_a, sync, sync_d, fall;
  int unsigned        rel, off, low_len;
  logic [2:0]         slot_idx;

  // Two-stage synchroniser plus edge history; idle line reads released (1)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= 1'b1;
      sync   <= 1'b1;
      sync_d <= 1'b1;
    end else begin
      sync_a <= lineIn;
      sync   <= sync_a;
      sync_d <= sync;
    end
  end

  assign fall      = sync_d & ~sync;
  assign timer_inc = (&timer) ? timer : timer + CNT_W'(1);

  // Frame image at line level, b4 first on the wire
  always_comb begin
    snap = {~keyState[0], 1'b1, ~keyState[1], ~keyState[2], ~keyState[3]};
`ifdef PBR_PARITY_EN
    snap[3] = snap[4] ^ snap[2] ^ snap[1] ^ snap[0];
`endif
  end

  always_comb begin
    state_n      = state;
    timer_n      = timer;
    frame_n      = frame;
    busy_n       = busy;
    frame_sent_n = 1'b0;
    start_err_n  = 1'b0;
    line_out_n   = 1'b1;
    rel          = 0;
    off          = 0;
    low_len      = 0;
    slot_idx     = 3'd0;

    case (state)
      S_IDLE: begin
        timer_n = '0;
        if (fall) begin
          state_n = S_START;
          timer_n = CNT_W'(1);
        end
      end
      S_START: begin
        timer_n = timer_inc;
        if (sync) begin
          if (32'(timer) < MIN_START) begin
            state_n = S_IDLE;
            timer_n = '0;
          end else begin
            state_n = S_TX;
            busy_n  = 1'b1;
            frame_n = snap;
          end
        end else if (32'(timer_inc) == MAX_START + 1) begin
          start_err_n = 1'b1;
          state_n     = S_ABORT;
        end
      end
      S_ABORT: begin
        timer_n = '0;
        if (sync) state_n = S_IDLE;
      end
      S_TX: begin
        timer_n = timer_inc;
        if (32'(timer_inc) == FRAME_END) begin
          state_n      = S_GUARD;
          frame_sent_n = 1'b1;
          timer_n      = CNT_W'(1);
        end
      end
      S_GUARD: begin
        if (32'(timer) >= GUARD) begin
          state_n = S_IDLE;
          busy_n  = 1'b0;
          timer_n = '0;
        end else begin
          timer_n = timer_inc;
        end
      end
      default: begin
        state_n = S_IDLE;
        timer_n = '0;
        busy_n  = 1'b0;
      end
    endcase

    // A low pulse may only begin at a slot start, so a slot already running when TX begins is skipped
    if (state_n == S_TX && 32'(timer_n) >= SLOT_START) begin
      rel      = 32'(timer_n) - SLOT_START;
      off      = rel % SLOT_LEN;
      slot_idx = 3'(rel / SLOT_LEN);
      low_len  = frame_n[3'd4 - slot_idx] ? ONE_LOW : ZERO_LOW;
      if (off == 0 || (!lineOut && off < low_len)) line_out_n = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      timer     <= '0;
      frame     <= '0;
      busy      <= 1'b0;
      frameSent <= 1'b0;
      startErr  <= 1'b0;
      lineOut   <= 1'b1;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      frame     <= frame_n;
      busy      <= busy_n;
      frameSent <= frame_sent_n;
      startErr  <= start_err_n;
      lineOut   <= line_out_n;
    end
  end

endmodule

// File: tb/tb_patient_button_responder.sv
// Bench for patient_button_responder: host start pulses from a vector table plus hand-written
// corner sequences; expected pulses/events are queued at stimulus time and matched by a monitor.
module tb_patient_button_responder;

  localparam int SLOT_START = 16;
  localparam int SLOT_LEN   = 11;
  localparam int ONE_LOW    = 2;
  localparam int ZERO_LOW   = 8;
  localparam int FRAME_END  = 71;
  localparam int GUARD      = 20;
  localparam int ERR_AT     = 13;

`ifdef PBR_PARITY_EN
  localparam logic [4:0] B0000 = 5'b10111;
  localparam logic [4:0] B0001 = 5'b01111;
  localparam logic [4:0] B0011 = 5'b00011;
  localparam logic [4:0] B1010 = 5'b10010;
  localparam logic [4:0] B1111 = 5'b00000;
`else
  localparam logic [4:0] B0000 = 5'b11111;
  localparam logic [4:0] B0001 = 5'b01111;
  localparam logic [4:0] B0011 = 5'b01011;
  localparam logic [4:0] B1010 = 5'b11010;
  localparam logic [4:0] B1111 = 5'b01000;
`endif

  typedef struct {
    int         width;
    logic [3:0] keys;
    bit         frame;
    bit         err;
    logic [4:0] bits;
  } vec_t;

  typedef struct {
    int start;
    int width;
  } pulse_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       host;
  logic       lineIn;
  logic       lineOut;
  logic [3:0] keyState;
  logic       busy;
  logic       frameSent;
  logic       startErr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  pulse_t pq[$];
  int     fsq[$];
  int     erq[$];
  vec_t   vecs[8];

  // Wired-AND line: host and device both pull low
  assign lineIn = host & lineOut;

  patient_button_responder dut (
    .clk(clk), .rst(rst), .lineIn(lineIn), .lineOut(lineOut), .keyState(keyState),
    .busy(busy), .frameSent(frameSent), .startErr(startErr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic at_cycle(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_frame(input int t0, input logic [4:0] bits, input bit with_sent);
    logic [4:0] b;
    b = bits;
    for (int k = 0; k < 5; k++)
      pq.push_back('{t0 + SLOT_START + SLOT_LEN * k, b[4-k] ? ONE_LOW : ZERO_LOW});
    if (with_sent) fsq.push_back(t0 + FRAME_END);
  endtask

  // Begin a host start pulse just after an edge; returns t0 (first cycle the synchronised line is low)
  task automatic start_low(output int t0);
    at_cycle(cyc + 1);
    host = 1'b0;
    t0   = cyc + 2;
  endtask

  task automatic release_start(input int t0, input int w);
    at_cycle(t0 - 2 + w);
    host = 1'b1;
  endtask

  // Monitor: measure every low pulse on lineOut and every event pulse, match against queues
  logic   lo_prev = 1'b1;
  int     lo_start = 0;
  pulse_t p;
  int     e;
  always @(negedge clk) begin
    if (lo_prev === 1'b1 && lineOut === 1'b0) lo_start = cyc;
    if (lo_prev === 1'b0 && lineOut === 1'b1) begin
      if (pq.size() == 0) check("pulse_unexpected", lo_start, -1);
      else begin
        p = pq.pop_front();
        check("pulse_start", lo_start, p.start);
        check("pulse_width", cyc - lo_start, p.width);
      end
    end
    if (frameSent === 1'b1) begin
      if (fsq.size() == 0) check("frame_sent_unexpected", cyc, -1);
      else begin
        e = fsq.pop_front();
        check("frame_sent_cycle", cyc, e);
      end
    end
    if (startErr === 1'b1) begin
      if (erq.size() == 0) check("start_err_unexpected", cyc, -1);
      else begin
        e = erq.pop_front();
        check("start_err_cycle", cyc, e);
      end
    end
    lo_prev = lineOut;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    vecs[0] = '{8,  4'b0000, 1'b1, 1'b0, B0000};
    vecs[1] = '{8,  4'b0001, 1'b1, 1'b0, B0001};
    vecs[2] = '{1,  4'b0000, 1'b0, 1'b0, 5'b00000};
    vecs[3] = '{20, 4'b0000, 1'b0, 1'b1, 5'b00000};
    vecs[4] = '{12, 4'b0011, 1'b1, 1'b0, B0011};
    vecs[5] = '{2,  4'b1010, 1'b1, 1'b0, B1010};
    vecs[6] = '{13, 4'b0101, 1'b0, 1'b1, 5'b00000};
    vecs[7] = '{8,  4'b1111, 1'b1, 1'b0, B1111};

    rst = 1'b1; host = 1'b1; keyState = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check("reset_lineOut", int'(lineOut), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_frameSent", int'(frameSent), 0);
    check("reset_startErr", int'(startErr), 0);
    rst = 1'b0;
    at_cycle(cyc + 5);

    for (int i = 0; i < 8; i++) begin
      keyState = vecs[i].keys;
      start_low(t0);
      if (vecs[i].frame) push_frame(t0, vecs[i].bits, 1'b1);
      if (vecs[i].err) erq.push_back(t0 + ERR_AT);
      release_start(t0, vecs[i].width);
      if (vecs[i].frame) begin
        at_cycle(t0 + vecs[i].width);
        check("busy_before_accept", int'(busy), 0);
        at_cycle(t0 + vecs[i].width + 1);
        check("busy_after_accept", int'(busy), 1);
        at_cycle(t0 + FRAME_END + GUARD - 1);
        check("busy_end_of_guard", int'(busy), 1);
        at_cycle(t0 + FRAME_END + GUARD);
        check("busy_released", int'(busy), 0);
      end else begin
        at_cycle(t0 + ERR_AT + 3);
        check("busy_rejected_start", int'(busy), 0);
      end
      at_cycle(t0 + 110);
    end

    // Start pulse during GUARD is ignored
    keyState = 4'b0000;
    start_low(t0);
    push_frame(t0, B0000, 1'b1);
    release_start(t0, 8);
    at_cycle(t0 + 75);
    host = 1'b0;
    at_cycle(t0 + 81);
    host = 1'b1;
    at_cycle(t0 + 85);
    check("guard_busy_held", int'(busy), 1);
    at_cycle(t0 + FRAME_END + GUARD);
    check("guard_busy_released", int'(busy), 0);
    at_cycle(t0 + 110);

    // Key change mid-frame only shows up in the next frame
    keyState = 4'b0001;
    start_low(t0);
    push_frame(t0, B0001, 1'b1);
    release_start(t0, 8);
    at_cycle(t0 + 30);
    keyState = 4'b0000;
    at_cycle(t0 + 110);
    start_low(t0);
    push_frame(t0, B0000, 1'b1);
    release_start(t0, 8);
    at_cycle(t0 + 110);

    // Reset mid-frame releases the line at once; slot 2 is cut short
    keyState = 4'b0011;
    start_low(t0);
    pq.push_back('{t0 + SLOT_START, ZERO_LOW});
    pq.push_back('{t0 + SLOT_START + SLOT_LEN, B0011[3] ? ONE_LOW : ZERO_LOW});
    pq.push_back('{t0 + SLOT_START + 2 * SLOT_LEN, 2});
    release_start(t0, 8);
    at_cycle(t0 + 39);
    check("midframe_busy", int'(busy), 1);
    at_cycle(t0 + 40);
    rst = 1'b1;
    #1;
    check("midreset_lineOut", int'(lineOut), 1);
    check("midreset_busy", int'(busy), 0);
    at_cycle(t0 + 45);
    rst = 1'b0;
    at_cycle(t0 + 110);

    // Recovery after reset
    keyState = 4'b1010;
    start_low(t0);
    push_frame(t0, B1010, 1'b1);
    release_start(t0, 8);
    at_cycle(t0 + 110);

    check("pulses_outstanding", pq.size(), 0);
    check("frame_sent_outstanding", fsq.size(), 0);
    check("start_err_outstanding", erq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
